// File: rtl/sdram_burst_writer.sv
// Write-side feeder for sdram_top: buffers a 16-bit word stream in a show-ahead FIFO
// and issues auto-incrementing burst writes over sdram_top's req/ack interface.
module sdram_burst_writer #(
    parameter int DEPTH  = 512,
    parameter int BURST  = 256,
    parameter int ADDR_W = 23
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_in_valid,
    input  logic [15:0]               i_in_data,
    output logic                      o_in_ready,
    input  logic [ADDR_W-1:0]         i_start_addr,
    input  logic                      i_start_load,
    input  logic                      i_flush,
    input  logic                      i_sdram_init_done,
    output logic                      o_sdram_wr_req,
    input  logic                      i_sdram_wr_ack,
    output logic [ADDR_W-1:0]         o_sys_wraddr,
    output logic [8:0]                o_sdwr_byte,
    output logic [15:0]               o_sys_data_in,
    output logic [$clog2(DEPTH):0]    o_level,
    output logic                      o_busy,
    output logic                      o_ack_err,
    output logic [1:0]                o_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] BURST_LVL = LW'(BURST);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              r_req;
    logic [ADDR_W-1:0] r_wraddr;
    logic [8:0]        r_byte;
    logic [8:0]        r_cnt;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_flush_pend;
    logic              r_ack_err;

    logic              w_push;
    logic              w_pop;
    logic              w_req_nxt;
    logic [ADDR_W-1:0] w_wraddr_nxt;
    logic [8:0]        w_byte_nxt;
    logic [8:0]        w_cnt_nxt;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic              w_flush_clr;
    logic [8:0]        w_len;

    // Upstream valid/ready: a word transfers on any rising edge where i_in_valid and
    // o_in_ready are both high; o_in_ready depends only on the FIFO level, never on i_in_valid.
    assign o_in_ready     = (r_level != DEPTH_LVL);
    assign w_push         = i_in_valid & o_in_ready;
    assign o_sys_data_in  = (r_level == '0) ? 16'h0000 : r_mem[r_rd_ptr];
    assign o_level        = r_level;
    assign o_sdram_wr_req = r_req;
    assign o_sys_wraddr   = r_wraddr;
    assign o_sdwr_byte    = r_byte;
    assign o_busy         = (r_state != S_IDLE);
    assign o_ack_err      = r_ack_err;
    assign o_state        = r_state;
    assign w_len          = (r_level >= BURST_LVL) ? 9'(BURST) : 9'(r_level);

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_in_data;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_req_nxt    = r_req;
        w_wraddr_nxt = r_wraddr;
        w_byte_nxt   = r_byte;
        w_cnt_nxt    = r_cnt;
        w_ptr_nxt    = r_ptr;
        w_flush_clr  = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start_load) w_ptr_nxt = i_start_addr;
                if (r_level == '0) w_flush_clr = 1'b1;
                // A load in the deciding cycle supplies that burst's address.
                if (i_sdram_init_done &&
                    (r_level >= BURST_LVL || (r_flush_pend && r_level != '0))) begin
                    w_wraddr_nxt = i_start_load ? i_start_addr : r_ptr;
                    w_byte_nxt   = w_len;
                    w_req_nxt    = 1'b1;
                    w_cnt_nxt    = 9'd0;
                    w_state_nxt  = S_REQ;
                end
            end
            S_REQ: begin
                if (i_sdram_wr_ack) begin
                    w_pop       = 1'b1;
                    w_cnt_nxt   = 9'd1;
                    w_req_nxt   = 1'b0;
                    w_state_nxt = (r_byte == 9'd1) ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                if (i_sdram_wr_ack && r_cnt != r_byte) begin
                    w_pop     = 1'b1;
                    w_cnt_nxt = r_cnt + 9'd1;
                    if ((r_cnt + 9'd1) == r_byte) w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_ptr_nxt   = r_ptr + ADDR_W'(r_byte);
                w_flush_clr = (r_level == '0);
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_req        <= 1'b0;
            r_wraddr     <= '0;
            r_byte       <= '0;
            r_cnt        <= '0;
            r_ptr        <= '0;
            r_flush_pend <= 1'b0;
            r_ack_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_req        <= w_req_nxt;
            r_wraddr     <= w_wraddr_nxt;
            r_byte       <= w_byte_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ptr        <= w_ptr_nxt;
            r_flush_pend <= i_flush | (r_flush_pend & ~w_flush_clr);
            if (i_sdram_wr_ack && !w_pop) r_ack_err <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_burst_writer.sv
// Bench for sdram_burst_writer: table-driven burst vectors, directed corner sequences
// and a randomized run against a queue-based reference model.
module tb_sdram_burst_writer;
    localparam int DEPTH  = 512;
    localparam int BURST  = 256;
    localparam int ADDR_W = 23;

    logic              clk = 1'b0;
    logic              i_rst_n;
    logic              i_in_valid;
    logic [15:0]       i_in_data;
    logic              o_in_ready;
    logic [ADDR_W-1:0] i_start_addr;
    logic              i_start_load;
    logic              i_flush;
    logic              i_sdram_init_done;
    logic              o_sdram_wr_req;
    logic              i_sdram_wr_ack;
    logic [ADDR_W-1:0] o_sys_wraddr;
    logic [8:0]        o_sdwr_byte;
    logic [15:0]       o_sys_data_in;
    logic [9:0]        o_level;
    logic              o_busy;
    logic              o_ack_err;
    logic [1:0]        o_state;

    sdram_burst_writer #(.DEPTH(DEPTH), .BURST(BURST), .ADDR_W(ADDR_W)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_in_valid(i_in_valid), .i_in_data(i_in_data),
        .o_in_ready(o_in_ready), .i_start_addr(i_start_addr), .i_start_load(i_start_load),
        .i_flush(i_flush), .i_sdram_init_done(i_sdram_init_done),
        .o_sdram_wr_req(o_sdram_wr_req), .i_sdram_wr_ack(i_sdram_wr_ack),
        .o_sys_wraddr(o_sys_wraddr), .o_sdwr_byte(o_sdwr_byte), .o_sys_data_in(o_sys_data_in),
        .o_level(o_level), .o_busy(o_busy), .o_ack_err(o_ack_err), .o_state(o_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Scoreboard and reference model state
    int                n_pass = 0;
    int                n_total = 0;
    logic [15:0]       exp_q[$];
    logic [ADDR_W-1:0] model_ptr;
    int                burst_left;
    int                cur_len;
    logic [15:0]       next_word;

    typedef struct {
        logic              load;
        logic [ADDR_W-1:0] addr;
        int                n;
        logic              fl;
        logic [ADDR_W-1:0] exp_addr;
        int                exp_len;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One clock: drive inputs at a negedge, update the model for the coming edge, advance.
    task automatic clk_cycle(input logic v, input logic ack, input logic fl);
        logic first;
        logic accept;
        first  = 1'b0;
        accept = v && (exp_q.size() < DEPTH);
        i_in_valid     = v;
        i_in_data      = next_word;
        i_sdram_wr_ack = ack;
        i_flush        = fl;
        if (ack && burst_left > 0) begin
            first = (burst_left == cur_len);
            if (exp_q.size() > 0) begin
                check("sys_data_in", o_sys_data_in, exp_q[0]);
                void'(exp_q.pop_front());
            end
            burst_left--;
            if (burst_left == 0) model_ptr = model_ptr + ADDR_W'(cur_len);
        end
        if (accept) begin
            exp_q.push_back(next_word);
            next_word = next_word + 16'd1;
        end
        @(negedge clk);
        i_in_valid = 1'b0; i_sdram_wr_ack = 1'b0; i_flush = 1'b0; i_start_load = 1'b0;
        if (first) check("wr_req_dropped", o_sdram_wr_req, 1'b0);
    endtask

    task automatic expect_req(input logic [ADDR_W-1:0] addr, input int len);
        int t;
        t = 0;
        while (!o_sdram_wr_req && t < 1000) begin
            clk_cycle(1'b0, 1'b0, 1'b0);
            t++;
        end
        check("wr_req_seen", o_sdram_wr_req, 1'b1);
        check("sys_wraddr", o_sys_wraddr, addr);
        check("sdwr_byte", o_sdwr_byte, len);
        cur_len    = len;
        burst_left = o_sdram_wr_req ? len : 0;
    endtask

    task automatic ack_burst(input int n, input logic push_too);
        for (int i = 0; i < n; i++) clk_cycle(push_too, 1'b1, 1'b0);
        check("busy_in_done", o_busy, 1'b1);
        clk_cycle(1'b0, 1'b0, 1'b0);
        check("busy_back_idle", o_busy, 1'b0);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_in_valid = 1'b0; i_in_data = '0; i_start_addr = '0; i_start_load = 1'b0;
        i_flush = 1'b0; i_sdram_wr_ack = 1'b0;
        exp_q.delete();
        burst_left = 0; cur_len = 0; model_ptr = '0; next_word = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, o_in_ready, 1'b1);
        check({tag, "_wr_req"}, o_sdram_wr_req, 1'b0);
        check({tag, "_wraddr"}, o_sys_wraddr, 0);
        check({tag, "_byte"}, o_sdwr_byte, 0);
        check({tag, "_data"}, o_sys_data_in, 0);
        check({tag, "_level"}, o_level, 0);
        check({tag, "_busy"}, o_busy, 1'b0);
        check({tag, "_ack_err"}, o_ack_err, 1'b0);
    endtask

    initial begin
        int any_req;
        int lvl_prev;
        int exp_len;
        logic draining;

        vecs[0] = '{1'b0, 23'h000000, 2,   1'b1, 23'h000100, 2};
        vecs[1] = '{1'b1, 23'h7FFFF0, 5,   1'b1, 23'h7FFFF0, 5};
        vecs[2] = '{1'b0, 23'h000000, 3,   1'b1, 23'h7FFFF5, 3};
        vecs[3] = '{1'b0, 23'h000000, 11,  1'b1, 23'h7FFFF8, 11};
        vecs[4] = '{1'b0, 23'h000000, 1,   1'b1, 23'h000003, 1};
        vecs[5] = '{1'b1, 23'h7FFF80, 256, 1'b0, 23'h7FFF80, 256};
        vecs[6] = '{1'b0, 23'h000000, 256, 1'b0, 23'h000080, 256};

        i_sdram_init_done = 1'b1;
        do_reset();
        check_reset_values("rst");
        i_rst_n = 1'b1;
        @(negedge clk);

        // Full burst: 0..255 pushed back to back
        for (int i = 0; i < BURST; i++) clk_cycle(1'b1, 1'b0, 1'b0);
        check("full_level", o_level, 256);
        check("full_req_not_yet", o_sdram_wr_req, 1'b0);
        clk_cycle(1'b0, 1'b0, 1'b0);
        check("full_req_next_cycle", o_sdram_wr_req, 1'b1);
        expect_req(23'h000000, 256);
        ack_burst(256, 1'b0);
        check("full_level_empty", o_level, 0);

        // Table of flush and full-burst vectors
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].load) begin
                i_start_addr = vecs[v].addr;
                i_start_load = 1'b1;
                model_ptr    = vecs[v].addr;
            end
            for (int i = 0; i < vecs[v].n; i++) clk_cycle(1'b1, 1'b0, 1'b0);
            if (vecs[v].fl) begin
                repeat (4) clk_cycle(1'b0, 1'b0, 1'b0);
                check($sformatf("vec%0d_no_req_before_flush", v), o_sdram_wr_req, 1'b0);
                clk_cycle(1'b0, 1'b0, 1'b1);
            end
            expect_req(vecs[v].exp_addr, vecs[v].exp_len);
            ack_burst(vecs[v].exp_len, 1'b0);
            check($sformatf("vec%0d_level", v), o_level, 0);
        end

        // Back-pressure with SDRAM not initialised, spurious ack, then concurrent push/ack
        i_sdram_init_done = 1'b0;
        any_req = 0;
        for (int i = 0; i < DEPTH; i++) begin
            clk_cycle(1'b1, 1'b0, 1'b0);
            if (o_sdram_wr_req) any_req = 1;
        end
        check("bp_level_full", o_level, 512);
        check("bp_in_ready_low", o_in_ready, 1'b0);
        check("bp_no_req_without_init", any_req, 0);
        clk_cycle(1'b1, 1'b0, 1'b0);
        check("bp_push_when_full", o_level, 512);
        clk_cycle(1'b0, 1'b1, 1'b0);
        check("spurious_ack_err", o_ack_err, 1'b1);
        check("spurious_ack_level", o_level, 512);
        i_sdram_init_done = 1'b1;
        expect_req(model_ptr, 256);
        clk_cycle(1'b1, 1'b1, 1'b0);
        check("conc_first_ack_level", o_level, 511);
        for (int i = 1; i < 256; i++) begin
            clk_cycle(1'b1, 1'b1, 1'b0);
            check("conc_level_hold", o_level, 511);
        end
        check("conc_busy_done", o_busy, 1'b1);
        clk_cycle(1'b0, 1'b0, 1'b0);
        expect_req(model_ptr, 256);
        ack_burst(256, 1'b0);
        clk_cycle(1'b0, 1'b0, 1'b1);
        expect_req(model_ptr, 255);
        ack_burst(255, 1'b0);
        check("conc_drained", o_level, 0);

        // Reset mid-burst
        for (int i = 0; i < BURST; i++) clk_cycle(1'b1, 1'b0, 1'b0);
        expect_req(model_ptr, 256);
        for (int i = 0; i < 100; i++) clk_cycle(1'b0, 1'b1, 1'b0);
        i_rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        do_reset();
        i_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            clk_cycle(1'b0, 1'b0, 1'b0);
            check("postrst_no_req", o_sdram_wr_req, 1'b0);
            check("postrst_level", o_level, 0);
        end

        // Randomized traffic against the queue model
        i_start_addr = 23'($urandom);
        i_start_load = 1'b1;
        model_ptr    = i_start_addr;
        lvl_prev     = 0;
        for (int cyc = 0; cyc < 9000; cyc++) begin
            logic v;
            logic a;
            logic f;
            draining = (cyc >= 3000);
            if (draining && exp_q.size() == 0 && burst_left == 0 && !o_busy) break;
            check("rnd_level", o_level, exp_q.size());
            check("rnd_in_ready", o_in_ready, exp_q.size() < DEPTH);
            if (o_sdram_wr_req && burst_left == 0) begin
                exp_len = (lvl_prev >= BURST) ? BURST : lvl_prev;
                check("rnd_wraddr", o_sys_wraddr, model_ptr);
                check("rnd_byte", o_sdwr_byte, exp_len);
                cur_len    = exp_len;
                burst_left = exp_len;
            end
            lvl_prev  = exp_q.size();
            v         = !draining && ($urandom_range(0, 1) == 1);
            a         = (burst_left > 0) && ($urandom_range(0, 3) != 0);
            f         = draining ? (cyc % 16 == 0) : ($urandom_range(0, 99) < 2);
            next_word = 16'($urandom);
            clk_cycle(v, a, f);
        end
        check("rnd_drained", exp_q.size(), 0);
        check("rnd_idle", o_busy, 1'b0);
        check("rnd_level_end", o_level, 0);
        check("rnd_no_ack_err", o_ack_err, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sdram_burst_writer.md
# sdram_burst_writer

Write-side feeder for `sdram_top`. Accepts a stream of 16-bit words through a valid/ready port and buffers them in an internal FIFO. Once a full burst is buffered, or a flush is requested, it drives `sdram_top`'s burst-write request/ack interface, supplying the start address, the burst length and one data word per ack. The write address auto-increments across bursts, so upstream producers (video capture, CPU DMA) can stream linearly into SDRAM.

## Interface
- `DEPTH`, 512: FIFO depth in words; power of two, ≥ `BURST`.
- `BURST`, 256: words per full burst; 1..256 (fits the 9-bit `sdwr_byte`).
- `ADDR_W`, 23: SDRAM word-address width.

Ports:
- `clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: upstream word valid.
- `in_data` in 16: upstream word.
- `in_ready` out 1: FIFO not full. A word is accepted when `in_valid & in_ready`.
- `start_addr` in `ADDR_W`: new base write address.
- `start_load` in 1: load `start_addr` into the address pointer. Honoured only in IDLE.
- `flush` in 1: one-cycle pulse requesting a write of the buffered remainder (<`BURST`).
- `sdram_init_done` in 1: from `sdram_top`. No request is issued while it is 0.
- `sdram_wr_req` out 1: burst write request to `sdram_top`.
- `sdram_wr_ack` in 1: one cycle per word consumed by `sdram_top`.
- `sys_wraddr` out `ADDR_W`: burst start address. Stable from request through DONE.
- `sdwr_byte` out 9: burst length in words. Stable from request through DONE.
- `sys_data_in` out 16: current word for `sdram_top`.
- `level` out log2(`DEPTH`)+1: FIFO occupancy.
- `busy` out 1: state ≠ IDLE.
- `ack_err` out 1: sticky; set when an ack arrives outside REQ/XFER or beyond the burst length.

## Operation
- The FIFO is show-ahead: `sys_data_in` always shows the head word.
  - Each cycle with `sdram_wr_ack=1` in REQ/XFER pops exactly one word.
  - The next word appears on `sys_data_in` the following cycle.
- Push and pop in the same cycle are both honoured; `level` is unchanged.
- A push while full cannot occur, because `in_ready=0`.
- State machine:
  - **IDLE**: If `sdram_init_done` and (`level ≥ BURST` or (`flush_pend` and `level > 0`)):
    - latch `len = min(level, BURST)` into `sdwr_byte`;
    - latch the pointer into `sys_wraddr`;
    - set `sdram_wr_req=1`, clear `cnt`, go to REQ.
  - **REQ**: Hold `sdram_wr_req=1` until the first ack. On that ack: pop, set `cnt=1`, clear `sdram_wr_req` on the next edge. Go to DONE if `len==1`, else to XFER.
  - **XFER**: On each ack: pop, `cnt++`. When `cnt` reaches `len`, go to DONE.
  - **DONE** (1 cycle): Pointer += `len`, modulo 2^`ADDR_W`, wrapping silently. Clear `flush_pend` if `level==0`. Go to IDLE.
- `flush_pend`:
  - set by `flush`;
  - cleared in DONE as above, or in IDLE if `level==0`.
  - While set, a partial burst is issued; if `level ≥ BURST`, full bursts go first.
- `start_load` outside IDLE is ignored.
- `start_load` coinciding with a request decision in IDLE: the loaded address is used for that burst.
- Bursts are never split. Keeping bursts within an SDRAM row/page is the producer's responsibility, via `start_addr` alignment.
- An ack in IDLE/DONE, or an ack with `cnt==len`, does not pop and sets `ack_err`.

## Timing
- Reset values:
  - `in_ready=1`;
  - `sdram_wr_req=0`, `sys_wraddr=0`, `sdwr_byte=0`, `sys_data_in=0`;
  - `level=0`, `busy=0`, `ack_err=0`;
  - pointer 0, `flush_pend=0`, state IDLE.
- Reset mid-burst aborts the burst and discards FIFO contents.
- Push to `level` update: 1 cycle.
- Write into an empty FIFO to `sys_data_in` valid: 1 cycle.
- Threshold reached to `sdram_wr_req=1`: 1 cycle (registered in IDLE).
- Last ack to IDLE: 2 cycles (→DONE, →IDLE).
- Minimum gap between consecutive requests: 3 cycles.
- `sdram_wr_req` is 0 no later than one cycle after the first ack. This is required by `sdram_top`'s req/ack convention.
- `in_ready` is combinational from `level`: 0 iff `level==DEPTH`.

## Test plan
- **Full burst:** reset, `init_done=1`, push 0..255 at 1 word/cycle.
  - `wr_req` rises one cycle after `level==256`, with `sys_wraddr=0`, `sdwr_byte=256`.
  - Acks 256 consecutive cycles → `sys_data_in` sequence 0..255, `level=0`.
  - Pointer becomes 256.
- **Flush remainder:** `start_load` with 0x7FFFF0, push 5 words, pulse `flush`.
  - Burst with `sdwr_byte=5`, `sys_wraddr=0x7FFFF0`.
  - Pointer becomes 0x7FFFF5; `flush_pend` clears.
- **Address wrap:** `start_load` with 0x7FFF80, two full bursts → second `sys_wraddr=0x000080`.
- **Back-pressure and concurrency:** push 512 words with acks stalled → `in_ready=0` at `level=512`.
  - Then push and ack in the same cycles → `level` holds.
  - All 512 words emerge in order.
- **Init gating and error:** `level ≥ 256` with `init_done=0` → no `wr_req`.
  - A spurious ack in IDLE sets `ack_err` and leaves `level` unchanged.
- **Reset mid-burst:** assert `rst_n=0` after 100 acks → all outputs at reset values immediately.
  - After release, `level=0` and no request is issued.
